q5_writeback: RTL and testbench
===============================

// Module: q5_writeback
// PURPOSE
//  Write-back stage: consumer end of the MEM/WB pipeline register. Selects ALU result or
//  load data, extracts and extends the load lane, commits to the 32x32 integer register
//  file and serves the two decode-stage read ports with same-cycle write bypass.
//  Also keeps a 64-bit retired-instruction counter (non-bubble instructions).
// PARAMETERS
//  CTRL_WIDTH   16  width of control bundle arriving from MEM/WB register
//  NOP_INSTR    32'h00000013  bubble encoding; never counted as retired
// PORTS
//  i_clk          in   1   clock
//  i_rst          in   1   reset, asynchronous, active-high
//  i_alu_out      in   32  ALU result; [1:0] is load byte offset
//  i_mem_rdata    in   32  aligned data-memory read word
//  i_reg_wr_port  in   5   destination register rd
//  i_ctrl_q4      in   CTRL_WIDTH  control bundle (bit fields per cpu_pkg)
//  i_instr        in   32  instruction in WB (funct3 = [14:12])
//  i_rs1_addr     in   5   decode read port 1 address
//  i_rs2_addr     in   5   decode read port 2 address
//  o_rs1_data     out  32  read port 1 data (combinational)
//  o_rs2_data     out  32  read port 2 data (combinational)
//  o_wb_en        out  1   write committed this cycle (to forwarding/hazard unit)
//  o_wb_addr      out  5   rd being written
//  o_wb_data      out  32  value being written
//  o_instret      out  64  retired-instruction count
// BEHAVIOUR
//  - Single clock i_clk; i_rst asynchronous, active-high; all state clears on assertion.
//  - Reset: all 32 registers = 0, o_instret = 0. o_wb_* and o_rs*_data are combinational
//    from inputs/state, so reset value follows inputs (regfile reads 0).
//  - wb_en = ctrl[CTRL_REG_WRITE] && (i_reg_wr_port != 0). o_wb_en = wb_en.
//  - Data select: ctrl[CTRL_MEM_TO_REG]=0 -> i_alu_out; =1 -> load-extract below.
//  - Load extract by funct3, off = i_alu_out[1:0]:
//     LB 000: sign-ext byte at mem_rdata[8*off+:8];  LBU 100: zero-ext same byte
//     LH 001: sign-ext half at mem_rdata[16*off[1]+:16]; LHU 101: zero-ext same half
//     LW 010: full word (off ignored); other funct3: full word.
//     Misaligned half (off[0]=1) uses off[1] only; no trap raised here.
//  - Commit: on posedge i_clk, if wb_en, regs[rd] <= o_wb_data. Latency 1 cycle to state.
//  - x0: never written; reads of address 0 return 0 regardless of bypass.
//  - Read ports: combinational. If wb_en && rsN_addr == rd (rd!=0) -> o_wb_data
//    (write-through bypass), else regs[rsN_addr]. Both ports may hit same rd.
//  - o_instret: increments by 1 on each posedge where i_instr != NOP_INSTR; 64-bit,
//    wraps 2^64-1 -> 0. Bubbles (NOP encoding) never count; a genuine addi x0,x0,0 also
//    does not count (accepted).
//  - Reset mid-operation: pending write discarded; counter and regfile return to 0 at once.
// STRUCTURE
//  - cpu_pkg: localparams CTRL_REG_WRITE=0, CTRL_MEM_TO_REG=1 (bit indices in ctrl
//    bundle), NOP_INSTR, funct3 load codes F3_LB/LH/LW/LBU/LHU.
//  - One sub-module: regfile_2r1w (32x32, x0 hardwired, bypass logic inside).
//  - Load extract and instret counter live in q5_writeback top.
// TESTING
//  - Reset: assert i_rst mid-run with writes pending -> all rs reads 0, o_instret=0.
//  - ALU write: ctrl REG_WRITE=1, MEM_TO_REG=0, rd=5, alu=0xDEADBEEF -> next cycle rs1=5
//    reads 0xDEADBEEF; same cycle rs2=5 bypass reads 0xDEADBEEF, o_wb_en=1.
//  - Loads: mem_rdata=0x80FF7F01, off=3 LB -> 0xFFFFFF80; LBU -> 0x00000080;
//    off=2 LH -> 0xFFFF80FF; LHU -> 0x000080FF; LW -> 0x80FF7F01.
//  - x0: write 0x12345678 to rd=0 with REG_WRITE=1 -> o_wb_en=0, rs1=0 reads 0.
//  - instret: 3 real instrs + 2 NOP_INSTR bubbles -> o_instret=3; preload/force count to
//    64'hFFFF_FFFF_FFFF_FFFF, one real instr -> 0.
//  - Dual hit: rs1=rs2=rd=7 during write of 0xA5A5A5A5 -> both ports 0xA5A5A5A5.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: control-bundle bit positions, bubble encoding and load funct3 codes.
package cpu_pkg;

   localparam int          CTRL_REG_WRITE  = 0;
   localparam int          CTRL_MEM_TO_REG = 1;

   // addi x0,x0,0 doubles as the pipeline bubble
   localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;

   localparam logic [2:0]  F3_LB           = 3'b000;
   localparam logic [2:0]  F3_LH           = 3'b001;
   localparam logic [2:0]  F3_LW           = 3'b010;
   localparam logic [2:0]  F3_LBU          = 3'b100;
   localparam logic [2:0]  F3_LHU          = 3'b101;

endpackage : cpu_pkg

// File: rtl/regfile_2r1w.sv
// 32x32 integer register file, two combinational read ports and one write port.
// x0 reads as zero; a write in flight is bypassed to readers of the same register.
module regfile_2r1w (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] wr_data,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   output logic [31:0] rs1_data,
   output logic [31:0] rs2_data
);

   logic [31:0] regs [32];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= 32'h0;
         end
      end else if (wr_en && (wr_addr != 5'd0)) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Address 0 wins over the bypass so x0 stays zero even if a caller asserts wr_en for it
   always_comb begin
      rs1_data = regs[rs1_addr];
      if (rs1_addr == 5'd0) begin
         rs1_data = 32'h0;
      end else if (wr_en && (rs1_addr == wr_addr)) begin
         rs1_data = wr_data;
      end
   end

   always_comb begin
      rs2_data = regs[rs2_addr];
      if (rs2_addr == 5'd0) begin
         rs2_data = 32'h0;
      end else if (wr_en && (rs2_addr == wr_addr)) begin
         rs2_data = wr_data;
      end
   end

endmodule : regfile_2r1w

// File: rtl/q5_writeback.sv
// Write-back stage: result select, load-lane extraction, register-file commit with
// same-cycle bypass, and a 64-bit retired-instruction counter.
module q5_writeback #(
   parameter int          CTRL_WIDTH  = 16,
   parameter logic [31:0] NOP_INSTR   = cpu_pkg::NOP_INSTR,
   // Counter value after reset; nonzero only to exercise the wrap without 2^64 cycles
   parameter logic [63:0] INSTRET_INIT = 64'd0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [31:0]           i_alu_out,
   input  logic [31:0]           i_mem_rdata,
   input  logic [4:0]            i_reg_wr_port,
   input  logic [CTRL_WIDTH-1:0] i_ctrl_q4,
   input  logic [31:0]           i_instr,
   input  logic [4:0]            i_rs1_addr,
   input  logic [4:0]            i_rs2_addr,
   output logic [31:0]           o_rs1_data,
   output logic [31:0]           o_rs2_data,
   output logic                  o_wb_en,
   output logic [4:0]            o_wb_addr,
   output logic [31:0]           o_wb_data,
   output logic [63:0]           o_instret
);

   logic        wb_en;
   logic [2:0]  funct3;
   logic [1:0]  off;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_data;
   logic [63:0] instret_q;

   assign funct3 = i_instr[14:12];
   assign off    = i_alu_out[1:0];
   assign wb_en  = i_ctrl_q4[cpu_pkg::CTRL_REG_WRITE] && (i_reg_wr_port != 5'd0);

   always_comb begin
      ld_byte = i_mem_rdata[7:0];
      case (off)
         2'd0:    ld_byte = i_mem_rdata[7:0];
         2'd1:    ld_byte = i_mem_rdata[15:8];
         2'd2:    ld_byte = i_mem_rdata[23:16];
         default: ld_byte = i_mem_rdata[31:24];
      endcase
   end

   // Misaligned halfwords fall back to the half selected by off[1]
   assign ld_half = off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

   always_comb begin
      load_data = i_mem_rdata;
      case (funct3)
         cpu_pkg::F3_LB:  load_data = {{24{ld_byte[7]}}, ld_byte};
         cpu_pkg::F3_LBU: load_data = {24'h0, ld_byte};
         cpu_pkg::F3_LH:  load_data = {{16{ld_half[15]}}, ld_half};
         cpu_pkg::F3_LHU: load_data = {16'h0, ld_half};
         default:         load_data = i_mem_rdata;
      endcase
   end

   assign o_wb_en   = wb_en;
   assign o_wb_addr = i_reg_wr_port;
   assign o_wb_data = i_ctrl_q4[cpu_pkg::CTRL_MEM_TO_REG] ? load_data : i_alu_out;

   regfile_2r1w u_regfile (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .wr_en    (wb_en),
      .wr_addr  (i_reg_wr_port),
      .wr_data  (o_wb_data),
      .rs1_addr (i_rs1_addr),
      .rs2_addr (i_rs2_addr),
      .rs1_data (o_rs1_data),
      .rs2_data (o_rs2_data)
   );

   // Bubbles share the NOP encoding, so any real addi x0,x0,0 is also left uncounted
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         instret_q <= INSTRET_INIT;
      end else if (i_instr != NOP_INSTR) begin
         instret_q <= instret_q + 64'd1;
      end
   end

   assign o_instret = instret_q;

   logic unused_ctrl;
   assign unused_ctrl = ^i_ctrl_q4[CTRL_WIDTH-1:2];

endmodule : q5_writeback

// File: tb/tb_q5_writeback.sv
// Directed bench for q5_writeback: reset, ALU/load write-back, bypass, x0 and instret.
module tb_q5_writeback;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] ADDI  = 32'h0050_0093;   // addi x1,x0,5 : a real instruction

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] alu_out;
   logic [31:0] mem_rdata;
   logic [4:0]  reg_wr_port;
   logic [15:0] ctrl;
   logic [31:0] instr;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data, rs2_data, wb_data;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [63:0] instret;

   logic [31:0] w_rs1_data, w_rs2_data, w_wb_data;
   logic        w_wb_en;
   logic [4:0]  w_wb_addr;
   logic [63:0] w_instret;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   q5_writeback dut (
      .i_clk(clk), .i_rst(rst), .i_alu_out(alu_out), .i_mem_rdata(mem_rdata),
      .i_reg_wr_port(reg_wr_port), .i_ctrl_q4(ctrl), .i_instr(instr),
      .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
      .o_rs1_data(rs1_data), .o_rs2_data(rs2_data), .o_wb_en(wb_en),
      .o_wb_addr(wb_addr), .o_wb_data(wb_data), .o_instret(instret)
   );

   // Second instance preloaded to all ones so the 64-bit wrap is reachable
   q5_writeback #(.INSTRET_INIT(64'hFFFF_FFFF_FFFF_FFFF)) dut_wrap (
      .i_clk(clk), .i_rst(rst), .i_alu_out(alu_out), .i_mem_rdata(mem_rdata),
      .i_reg_wr_port(reg_wr_port), .i_ctrl_q4(ctrl), .i_instr(instr),
      .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
      .o_rs1_data(w_rs1_data), .o_rs2_data(w_rs2_data), .o_wb_en(w_wb_en),
      .o_wb_addr(w_wb_addr), .o_wb_data(w_wb_data), .o_instret(w_instret)
   );

   task automatic idle();
      ctrl = 16'h0; instr = NOP; alu_out = 32'h0; mem_rdata = 32'h0;
      reg_wr_port = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst = 1'b1;
      step();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic write_reg(input logic [4:0] rd, input logic [31:0] val);
      @(negedge clk);
      ctrl = 16'h0001; reg_wr_port = rd; alu_out = val;
      step();
      @(negedge clk);
      ctrl = 16'h0;
   endtask

   task automatic test_reset();
      do_reset();
      rs1_addr = 5'd5; rs2_addr = 5'd31;
      #1;
      vectors++;
      if (rs1_data !== 32'h0) begin
         miscompares++; $display("FAIL reset_rs1: got %h want %h", rs1_data, 32'h0);
      end
      vectors++;
      if (rs2_data !== 32'h0) begin
         miscompares++; $display("FAIL reset_rs2: got %h want %h", rs2_data, 32'h0);
      end
      vectors++;
      if (instret !== 64'd0) begin
         miscompares++; $display("FAIL reset_instret: got %h want %h", instret, 64'd0);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      #1;
      vectors++;
      if (w_instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         miscompares++; $display("FAIL wrap_preload: got %h want %h", w_instret, 64'hFFFF_FFFF_FFFF_FFFF);
      end
      @(negedge clk);
      instr = ADDI;
      step();
      @(negedge clk);
      instr = NOP;
      vectors++;
      if (w_instret !== 64'd0) begin
         miscompares++; $display("FAIL wrap_to_zero: got %h want %h", w_instret, 64'd0);
      end
      vectors++;
      if (instret !== 64'd1) begin
         miscompares++; $display("FAIL wrap_main_count: got %h want %h", instret, 64'd1);
      end
   endtask

   task automatic test_alu_write();
      @(negedge clk);
      ctrl = 16'h0001; reg_wr_port = 5'd5; alu_out = 32'hDEADBEEF;
      rs1_addr = 5'd5; rs2_addr = 5'd5;
      #1;
      vectors++;
      if (wb_en !== 1'b1) begin
         miscompares++; $display("FAIL alu_wb_en: got %b want %b", wb_en, 1'b1);
      end
      vectors++;
      if (rs2_data !== 32'hDEADBEEF) begin
         miscompares++; $display("FAIL alu_bypass_rs2: got %h want %h", rs2_data, 32'hDEADBEEF);
      end
      vectors++;
      if (wb_addr !== 5'd5 || wb_data !== 32'hDEADBEEF) begin
         miscompares++; $display("FAIL alu_wb_bus: got %0d/%h want 5/%h", wb_addr, wb_data, 32'hDEADBEEF);
      end
      step();
      @(negedge clk);
      ctrl = 16'h0; alu_out = 32'h0; rs2_addr = 5'd0;
      #1;
      vectors++;
      if (rs1_data !== 32'hDEADBEEF) begin
         miscompares++; $display("FAIL alu_commit_rs1: got %h want %h", rs1_data, 32'hDEADBEEF);
      end
      vectors++;
      if (wb_en !== 1'b0) begin
         miscompares++; $display("FAIL alu_idle_wb_en: got %b want %b", wb_en, 1'b0);
      end
   endtask

   task automatic test_loads();
      logic [2:0]  f3_tab  [9] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010,
                                   3'b000, 3'b000, 3'b001, 3'b101};
      logic [1:0]  off_tab [9] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd3, 2'd1};
      logic [31:0] exp_tab [9] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF,
                                   32'h80FF7F01, 32'h00000001, 32'h0000007F, 32'hFFFF80FF,
                                   32'h00007F01};
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         mem_rdata   = 32'h80FF7F01;
         ctrl        = 16'h0003;
         reg_wr_port = 5'd10;
         alu_out     = {28'h0001000, 2'b00, off_tab[i]};
         instr       = {17'h0, f3_tab[i], 5'd10, 7'b0000011};
         rs1_addr    = 5'd10; rs2_addr = 5'd0;
         #1;
         vectors++;
         if (wb_data !== exp_tab[i]) begin
            miscompares++;
            $display("FAIL load_extract[%0d] f3=%b off=%0d: got %h want %h",
                     i, f3_tab[i], off_tab[i], wb_data, exp_tab[i]);
         end
         step();
         @(negedge clk);
         ctrl = 16'h0; instr = NOP;
         #1;
         vectors++;
         if (rs1_data !== exp_tab[i]) begin
            miscompares++;
            $display("FAIL load_commit[%0d]: got %h want %h", i, rs1_data, exp_tab[i]);
         end
      end
   endtask

   task automatic test_x0();
      @(negedge clk);
      ctrl = 16'h0001; reg_wr_port = 5'd0; alu_out = 32'h12345678;
      rs1_addr = 5'd0; rs2_addr = 5'd0;
      #1;
      vectors++;
      if (wb_en !== 1'b0) begin
         miscompares++; $display("FAIL x0_wb_en: got %b want %b", wb_en, 1'b0);
      end
      vectors++;
      if (rs1_data !== 32'h0) begin
         miscompares++; $display("FAIL x0_bypass: got %h want %h", rs1_data, 32'h0);
      end
      step();
      @(negedge clk);
      ctrl = 16'h0;
      #1;
      vectors++;
      if (rs1_data !== 32'h0) begin
         miscompares++; $display("FAIL x0_commit: got %h want %h", rs1_data, 32'h0);
      end
      // MEM_TO_REG without REG_WRITE must not commit
      @(negedge clk);
      ctrl = 16'h0002; reg_wr_port = 5'd12; alu_out = 32'h0; mem_rdata = 32'h55AA55AA;
      instr = NOP; rs1_addr = 5'd12;
      step();
      @(negedge clk);
      ctrl = 16'h0;
      #1;
      vectors++;
      if (rs1_data !== 32'h0) begin
         miscompares++; $display("FAIL no_regwrite: got %h want %h", rs1_data, 32'h0);
      end
   endtask

   task automatic test_dual_hit();
      write_reg(5'd7, 32'h11111111);
      @(negedge clk);
      ctrl = 16'h0001; reg_wr_port = 5'd7; alu_out = 32'hA5A5A5A5;
      rs1_addr = 5'd7; rs2_addr = 5'd7;
      #1;
      vectors++;
      if (rs1_data !== 32'hA5A5A5A5 || rs2_data !== 32'hA5A5A5A5) begin
         miscompares++;
         $display("FAIL dual_hit: got %h/%h want %h", rs1_data, rs2_data, 32'hA5A5A5A5);
      end
      step();
      @(negedge clk);
      ctrl = 16'h0; rs2_addr = 5'd5;
      #1;
      vectors++;
      if (rs1_data !== 32'hA5A5A5A5 || rs2_data !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL dual_after: got %h/%h want %h/%h", rs1_data, rs2_data,
                  32'hA5A5A5A5, 32'hDEADBEEF);
      end
   endtask

   task automatic test_instret();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         instr = (i == 1 || i == 3) ? NOP : ADDI;
         step();
      end
      @(negedge clk);
      instr = NOP;
      step();
      vectors++;
      if (instret !== 64'd3) begin
         miscompares++; $display("FAIL instret_count: got %0d want %0d", instret, 3);
      end
   endtask

   task automatic test_reset_mid();
      write_reg(5'd5, 32'hCAFEF00D);
      @(negedge clk);
      instr = ADDI; ctrl = 16'h0001; reg_wr_port = 5'd9; alu_out = 32'h9999_0000;
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (instret !== 64'd0) begin
         miscompares++; $display("FAIL mid_reset_instret: got %0d want %0d", instret, 0);
      end
      step();
      @(negedge clk);
      ctrl = 16'h0; instr = NOP; rs1_addr = 5'd9; rs2_addr = 5'd5;
      rst = 1'b0;
      #1;
      vectors++;
      if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
         miscompares++;
         $display("FAIL mid_reset_regs: got %h/%h want %h", rs1_data, rs2_data, 32'h0);
      end
      step();
      vectors++;
      if (instret !== 64'd0) begin
         miscompares++; $display("FAIL post_reset_instret: got %0d want %0d", instret, 0);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_wrap();
      test_alu_write();
      test_loads();
      test_x0();
      test_dual_hit();
      test_instret();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: run exceeded time limit");
      $fatal(1);
   end

endmodule : tb_q5_writeback
